fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage of the 32-bit MIPS pipeline.
- Owns the architectural PC and issues requests to a variable-latency instruction memory using a req/ack handshake.
- Delivers {instruction, pc, pc+4} to decode with a valid/stall handshake.
- Handles branch/jump redirects and exception vectoring, including redirects that arrive while a memory request is in flight.

Parameters:
RESET_PC  32'h0000_0000  PC loaded on reset
EXC_VECTOR  32'h0000_0080  PC loaded on exception
PC_INCR  4  sequential PC increment in bytes

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address; word aligned, bits [1:0] always 00
imem_ack  in  1  memory returns imem_rdata this cycle for the current request
imem_rdata  in  32  instruction word, valid when imem_ack=1
stall_in  in  1  decode cannot accept a new instruction this cycle
redirect_valid  in  1  branch/jump taken; flush and fetch from redirect_pc
redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 00
exc_valid  in  1  exception; flush and fetch from EXC_VECTOR
if_valid  out  1  if_inst/if_pc/if_pc_plus4 hold a valid fetched instruction
if_inst  out  32  fetched instruction
if_pc  out  32  address of if_inst
if_pc_plus4  out  32  if_pc + PC_INCR, modulo 2^32

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, pc=RESET_PC, pending_pc=0, skid=0.
  - if_valid=0, if_inst=0, if_pc=0, if_pc_plus4=0.
  - imem_req=0, imem_addr=RESET_PC.
- States: IDLE, FETCH, HOLD, DRAIN.
  - IDLE: imem_req=0. Unconditional move to FETCH on the next edge. This gives one bubble cycle after reset deassertion.
  - FETCH: imem_req=1, imem_addr=pc. Once asserted, req and addr stay stable until ack; a request is never withdrawn.
- FETCH ack handling, when no flush is active:
  - Slot free (if_valid=0 or stall_in=0): load the output registers with {imem_rdata, pc, pc+4}, set if_valid=1, set pc=pc+4, stay in FETCH.
  - Slot occupied and stalled: capture {imem_rdata, pc} into the skid register, set pc=pc+4, go to HOLD.
- Zero-wait memory (ack in the same cycle as req) sustains 1 instruction/cycle.
- Output slot with no ack: if stall_in=0, clear if_valid (instruction consumed, no replacement).
- HOLD:
  - imem_req=0.
  - When stall_in=0: move skid to the output registers, set if_valid=1, go to FETCH.
  - Output holds steady while stalled.
- Flush: flush = exc_valid | redirect_valid. target = EXC_VECTOR if exc_valid, else {redirect_pc[31:2], 2'b00). Exception has priority.
  - Every flush clears if_valid on the next edge, regardless of stall_in.
  - FETCH with ack this cycle: discard imem_rdata, pc=target, stay in FETCH.
  - FETCH without ack: pending_pc=target, go to DRAIN.
  - HOLD: discard skid, pc=target, go to FETCH.
  - DRAIN: pending_pc=target (latest flush wins), stay in DRAIN.
  - IDLE: pc=target, then go to FETCH as normal.
- DRAIN:
  - imem_req=1, imem_addr=old pc (held stable).
  - On ack: discard data, pc=pending_pc, go to FETCH.
  - If a flush arrives in the same cycle as ack: use the new target.
- Arithmetic: pc and if_pc_plus4 wrap 32'hFFFF_FFFC -> 32'h0000_0000. No overflow flag.
- Latency: with zero-wait memory, if_valid rises 2 cycles after reset release. A redirect produces a minimum 1-cycle bubble.
- imem_ack while imem_req=0 is ignored.

Decomposition:
- fetch_pkg:
  - State enum (IDLE, FETCH, HOLD, DRAIN).
  - PC_INCR.
  - Default RESET_PC and EXC_VECTOR.
  - 32-bit word-address type.
- Sub-module fetch_skid: one-entry {inst, pc} register with load/unload/clear. The top level holds the FSM, pc, pending_pc and the output register.

Test Plan:
- Reset: release reset; ack tied 1; rdata = addr^32'hA5A5_A5A5 -> imem_req=0 for 1 cycle, then addresses 0,4,8,... back-to-back; if_pc=0 with if_inst=32'hA5A5_A5A5 in cycle 2.
- Stall: stall_in=1 for 3 cycles mid-stream with ack tied 1 -> one word enters skid, FSM in HOLD, imem_req=0, outputs stable; after release no instruction is lost or duplicated (pc sequence continuous).
- Slow memory: ack after 3 wait cycles -> imem_addr stable through the wait; if_valid pulses once per ack.
- Redirect in flight: redirect_pc=32'h0000_1003 in cycle 1 of a 3-cycle wait -> DRAIN; stale data discarded; next imem_addr=32'h0000_1000; no stale if_valid.
- Exception vs. redirect: exc_valid and redirect_valid together with redirect_pc=32'h400 -> next fetch at 32'h80; if_valid=0 next cycle even with stall_in=1.
- Wrap and async reset: redirect to 32'hFFFF_FFFC -> next fetch 0, if_pc_plus4=0. Assert reset mid-DRAIN -> immediate IDLE, imem_req=0, if_valid=0 without waiting for clk.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch
//               controller: FSM state encoding, word-address type, default
//               reset/exception PCs, sequential increment, alignment helper.
// Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    typedef logic [31:0] word_addr_t;

    localparam word_addr_t FETCH_PC_INCR    = 32'd4;
    localparam word_addr_t FETCH_RESET_PC   = 32'h0000_0000;
    localparam word_addr_t FETCH_EXC_VECTOR = 32'h0000_0080;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // Instruction addresses are always word aligned; low bits are dropped.
    function automatic word_addr_t align_word(input word_addr_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid
// Description : One-entry {inst, pc} holding register used when memory
//               returns a word while decode is stalled on the current one.
// Ports       : clk, reset      - clock, async active-high reset
//               load            - capture load_inst/load_pc, mark valid
//               unload          - entry consumed, mark invalid
//               clear           - discard entry (flush), zero contents
//               load_inst/pc    - data to capture
//               valid/inst/pc   - stored entry
// Revision    : 1.0  initial release
// ============================================================================
module fetch_skid
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       unload,
    input  logic       clear,
    input  logic [31:0] load_inst,
    input  word_addr_t load_pc,
    output logic       valid,
    output logic [31:0] inst,
    output word_addr_t pc
);

    logic       valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    word_addr_t pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
            inst_d  = '0;
            pc_d    = '0;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = load_inst;
            pc_d    = load_pc;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign inst  = inst_q;
    assign pc    = pc_q;

endmodule : fetch_skid
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the PC, drives a req/ack
//               instruction memory, presents {inst, pc, pc+4} to decode with
//               a valid/stall handshake, and handles redirects/exceptions,
//               including those that arrive while a request is outstanding.
// Ports       : clk, reset           - clock, async active-high reset
//               imem_req/imem_addr   - fetch request and word address
//               imem_ack/imem_rdata  - memory completion and data
//               stall_in             - decode not accepting this cycle
//               redirect_valid/pc    - taken branch/jump target
//               exc_valid            - exception, vector to EXC_VECTOR
//               if_valid/if_inst/if_pc/if_pc_plus4 - decode output slot
// Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter word_addr_t RESET_PC   = FETCH_RESET_PC,
    parameter word_addr_t EXC_VECTOR = FETCH_EXC_VECTOR,
    parameter word_addr_t PC_INCR    = FETCH_PC_INCR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_valid,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    fetch_state_e state_q, state_d;
    word_addr_t   pc_q, pc_d;
    word_addr_t   pending_pc_q, pending_pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_inst_q, if_inst_d;
    word_addr_t   if_pc_q, if_pc_d;
    word_addr_t   if_pc_plus4_q, if_pc_plus4_d;

    logic         flush;
    word_addr_t   target;
    logic         ack_acc;
    logic         slot_free;

    logic         skid_load, skid_unload, skid_clear;
    logic         skid_valid;
    logic [31:0]  skid_inst;
    word_addr_t   skid_pc;

    fetch_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .load_inst (imem_rdata),
        .load_pc   (pc_q),
        .valid     (skid_valid),
        .inst      (skid_inst),
        .pc        (skid_pc)
    );

    // Exception outranks a simultaneous redirect. An ack is only meaningful
    // while a request is actually outstanding.
    always_comb begin
        flush     = exc_valid | redirect_valid;
        target    = exc_valid ? align_word(EXC_VECTOR) : align_word(redirect_pc);
        ack_acc   = imem_ack & imem_req;
        slot_free = ~if_valid_q | ~stall_in;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (flush) begin
                    if (!ack_acc) state_d = ST_DRAIN;
                end else if (ack_acc && !slot_free) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD:  if (flush || !stall_in) state_d = ST_FETCH;
            ST_DRAIN: if (ack_acc) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory-side outputs. In DRAIN the stale request stays on the bus
    // unchanged until memory completes it, since requests are never withdrawn.
    always_comb begin
        imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        imem_addr = pc_q;
    end

    // PC, pending target and decode output slot
    always_comb begin
        pc_d          = pc_q;
        pending_pc_d  = pending_pc_q;
        if_valid_d    = if_valid_q & stall_in;   // consumed when not stalled
        if_inst_d     = if_inst_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;
        skid_clear    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flush) pc_d = target;
            end
            ST_FETCH: begin
                if (flush) begin
                    if (ack_acc) pc_d = target;
                    else         pending_pc_d = target;
                end else if (ack_acc) begin
                    if (slot_free) begin
                        if_valid_d    = 1'b1;
                        if_inst_d     = imem_rdata;
                        if_pc_d       = pc_q;
                        if_pc_plus4_d = pc_q + PC_INCR;
                    end else begin
                        skid_load = 1'b1;
                    end
                    pc_d = pc_q + PC_INCR;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    skid_clear = 1'b1;
                    pc_d       = target;
                end else if (!stall_in) begin
                    if_valid_d    = skid_valid;
                    if_inst_d     = skid_inst;
                    if_pc_d       = skid_pc;
                    if_pc_plus4_d = skid_pc + PC_INCR;
                    skid_unload   = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Latest flush wins, including one coinciding with the ack.
                if (flush) pending_pc_d = target;
                if (ack_acc) pc_d = flush ? target : pending_pc_q;
            end
            default: ;
        endcase

        if (flush) if_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= align_word(RESET_PC);
            pending_pc_q  <= '0;
            if_valid_q    <= 1'b0;
            if_inst_q     <= '0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
        end else begin
            pc_q          <= pc_d;
            pending_pc_q  <= pending_pc_d;
            if_valid_q    <= if_valid_d;
            if_inst_q     <= if_inst_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_inst     = if_inst_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. A transaction-level model
//               (next fetch address, optional pending target, optional skid
//               entry, output slot) predicts the DUT outputs every cycle;
//               directed literal checks pin key points of the model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;
    localparam logic [31:0] EXC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_in = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        exc_valid = 1'b0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (EXC),
        .PC_INCR    (32'd4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_valid      (exc_valid),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    // Memory: data is a fixed function of the address. Either ack is tied
    // high (even with no request) or it arrives after mem_wait wait cycles.
    logic ack_tie = 1'b1;
    int   mem_wait = 0;
    int   wait_cnt;

    assign imem_rdata = imem_addr ^ KEY;
    assign imem_ack   = ack_tie | (imem_req && (wait_cnt >= mem_wait));

    always @(posedge clk or posedge reset) begin
        if (reset)                      wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_bubble;      // first cycle after reset: nothing requested
    logic [31:0] m_addr;        // address currently requested / next to fetch
    logic        m_pend_v;      // in-flight request is stale, target waiting
    logic [31:0] m_pend;
    logic        m_skid_v;      // fetched word parked while decode stalled
    logic [31:0] m_skid_inst, m_skid_pc;
    logic        m_out_v;
    logic [31:0] m_out_inst, m_out_pc;

    always @(negedge clk) begin
        logic        exp_req, m_ack, flush, acc, free, nv;
        logic [31:0] tgt;
        if (reset) begin
            m_bubble = 1'b1; m_addr = 32'h0; m_pend_v = 1'b0; m_pend = 32'h0;
            m_skid_v = 1'b0; m_skid_inst = 32'h0; m_skid_pc = 32'h0;
            m_out_v = 1'b0; m_out_inst = 32'h0; m_out_pc = 32'h0;
            chk("rst_req",   {31'h0, imem_req}, 32'h0);
            chk("rst_addr",  imem_addr, 32'h0);
            chk("rst_valid", {31'h0, if_valid}, 32'h0);
            chk("rst_inst",  if_inst, 32'h0);
            chk("rst_pc",    if_pc, 32'h0);
            chk("rst_pc4",   if_pc_plus4, 32'h0);
        end else begin
            exp_req = !m_bubble && !m_skid_v;
            chk("req",   {31'h0, imem_req}, {31'h0, exp_req});
            chk("addr",  imem_addr, m_addr);
            chk("valid", {31'h0, if_valid}, {31'h0, m_out_v});
            if (m_out_v) begin
                chk("inst", if_inst, m_out_inst);
                chk("pc",   if_pc, m_out_pc);
                chk("pc4",  if_pc_plus4, m_out_pc + 32'd4);
            end

            // advance to the state after the coming rising edge
            m_ack = ack_tie || (exp_req && (wait_cnt >= mem_wait));
            acc   = exp_req && m_ack;
            flush = exc_valid || redirect_valid;
            tgt   = exc_valid ? EXC : {redirect_pc[31:2], 2'b00};
            free  = !m_out_v || !stall_in;
            nv    = m_out_v && stall_in;
            if (m_bubble) begin
                m_bubble = 1'b0;
                if (flush) m_addr = tgt;
            end else if (m_skid_v) begin
                if (flush) begin
                    m_skid_v = 1'b0; m_addr = tgt;
                end else if (!stall_in) begin
                    m_out_inst = m_skid_inst; m_out_pc = m_skid_pc; nv = 1'b1;
                    m_skid_v = 1'b0;
                end
            end else if (m_pend_v) begin
                if (flush) m_pend = tgt;
                if (acc) begin
                    m_addr = m_pend; m_pend_v = 1'b0;
                end
            end else begin
                if (flush) begin
                    if (acc) m_addr = tgt;
                    else begin m_pend_v = 1'b1; m_pend = tgt; end
                end else if (acc) begin
                    if (free) begin
                        m_out_inst = m_addr ^ KEY; m_out_pc = m_addr; nv = 1'b1;
                    end else begin
                        m_skid_v = 1'b1; m_skid_inst = m_addr ^ KEY; m_skid_pc = m_addr;
                    end
                    m_addr = m_addr + 32'd4;
                end
            end
            if (flush) nv = 1'b0;
            m_out_v = nv;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_mid_request(input string name);
        int n = 0;
        while (!(imem_req && wait_cnt == 1) && n < 50) begin
            tick();
            n++;
        end
        chk(name, {31'h0, n < 50}, 32'h1);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // reset release: one bubble, then back-to-back fetches
        chk("bubble_req", {31'h0, imem_req}, 32'h0);
        tick();
        chk("first_req",  {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        tick();
        chk("first_valid", {31'h0, if_valid}, 32'h1);
        chk("first_pc",    if_pc, 32'h0);
        chk("first_inst",  if_inst, 32'hA5A5_A5A5);
        chk("second_addr", imem_addr, 32'h4);
        repeat (3) tick();

        // decode stall mid-stream
        stall_in = 1'b1;
        tick();
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        tick();
        tick();
        stall_in = 1'b0;
        repeat (5) tick();

        // slow memory: 3 wait cycles per access
        ack_tie  = 1'b0;
        mem_wait = 3;
        repeat (14) tick();

        // redirect while a request is in flight
        wait_mid_request("redir_sync_timeout");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1003;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        chk("drain_req", {31'h0, imem_req}, 32'h1);
        n = 0;
        while (imem_addr != 32'h0000_1000 && n < 20) begin
            tick();
            n++;
        end
        chk("redir_addr", imem_addr, 32'h0000_1000);
        repeat (6) tick();

        // exception together with redirect, decode stalled
        ack_tie = 1'b1;
        tick();
        stall_in       = 1'b1;
        exc_valid      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        tick();
        exc_valid      = 1'b0;
        redirect_valid = 1'b0;
        chk("exc_addr",  imem_addr, 32'h0000_0080);
        chk("exc_valid", {31'h0, if_valid}, 32'h0);
        stall_in = 1'b0;
        repeat (3) tick();

        // wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc",   if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4",  if_pc_plus4, 32'h0);
        chk("wrap_next", imem_addr, 32'h0);
        repeat (3) tick();

        // asynchronous reset while draining
        ack_tie  = 1'b0;
        mem_wait = 3;
        wait_mid_request("drain_sync_timeout");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        tick();
        redirect_valid = 1'b0;
        chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("async_req",   {31'h0, imem_req}, 32'h0);
        chk("async_valid", {31'h0, if_valid}, 32'h0);
        chk("async_addr",  imem_addr, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        reset    = 1'b0;
        ack_tie  = 1'b1;
        mem_wait = 0;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_fetch_ctrl
`default_nettype wire
